// File: rtl/debounce_pkg.sv
// Shared defaults and the highest-index priority encoder for input_debounce_array.
package debounce_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 1000000;
  localparam int unsigned DEFAULT_REPEAT_DELAY   = 50000000;
  localparam int unsigned DEFAULT_REPEAT_PERIOD  = 10000000;

  // Widest channel count the encoder handles; narrower users zero-extend.
  localparam int unsigned MAX_CH = 64;

  // Returns a vector with only the highest set bit of vec kept.
  function automatic logic [MAX_CH-1:0] highest_onehot(input logic [MAX_CH-1:0] vec);
    logic [MAX_CH-1:0] result;
    result = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i] && (result == '0)) begin
        result[i] = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, agreement counter, edge pulses and,
// when DEBOUNCE_AUTOREPEAT_EN is defined, hold-to-repeat press generation.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int unsigned REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sync1;
  logic             sync2;
  logic             stable_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The synchronised level has disagreed long enough to be taken as the new level.
  assign accept = (sync2 != stable_q) && (cnt == CNT_LAST);

  // NOTE: every register here, the synchroniser included, is cleared by the async
  // reset so a held input must be fully re-qualified after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt      <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync2 see the old sync1 on the same edge.
      sync1  <= raw;
      sync2  <= sync1;
      rise_q <= accept & sync2;
      fall_q <= accept & ~sync2;
      if ((sync2 == stable_q) || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (accept) begin
        stable_q <= sync2;
      end
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_periodic;
  logic             rep_hit;
  logic             press_q;

  // First repeat waits the long delay, later ones the short period; a fall on
  // this edge suppresses any repeat that would coincide with it.
  assign rep_hit = stable_q && !accept &&
                   (rep_cnt == (rep_periodic ? REP_PERIOD_LAST : REP_DELAY_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt      <= '0;
      rep_periodic <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      press_q <= (accept & sync2) | rep_hit;
      if (!stable_q || accept) begin
        rep_cnt      <= '0;
        rep_periodic <= 1'b0;
      end else if (rep_hit) begin
        rep_cnt      <= '0;
        rep_periodic <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end

  assign press = press_q;
`else
  assign press = rise_q;
`endif

endmodule

// File: rtl/input_debounce_array.sv
// NUM_CH independent debouncers plus a highest-index one-hot summary.
// Optional hold-to-repeat on press is enabled by defining DEBOUNCE_AUTOREPEAT_EN.
module input_debounce_array
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH         = 6,
  parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int unsigned REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] stable,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] press,
  output logic [NUM_CH-1:0] onehot,
  output logic              any_active
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_channel (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (raw_in[ch]),
      .stable (stable[ch]),
      .rise   (rise[ch]),
      .fall   (fall[ch]),
      .press  (press[ch])
    );
  end

  logic [MAX_CH-1:0] stable_wide;
  logic [MAX_CH-1:0] onehot_wide;

  // The encoder is fixed-width; bits above NUM_CH are always zero.
  assign stable_wide = MAX_CH'(stable);
  assign onehot_wide = highest_onehot(stable_wide);
  assign onehot      = onehot_wide[NUM_CH-1:0];
  assign any_active  = |onehot_wide;

endmodule

// File: doc/input_debounce_array.md
# input_debounce_array

Parametrised multi-channel debouncer for raw push-buttons and slide switches. It feeds the step/hold option logic and any other user-input consumer. Each of NUM_CH inputs is synchronised and debounced by a saturating-free counter. The block then produces a level output per channel, one-cycle rise and fall pulses, a press pulse with optional hold-to-repeat, and a highest-index-wins one-hot summary.

## Interface
Parameters:
- NUM_CH, 6: number of independent input channels (≥1).
- DEBOUNCE_LIMIT, 1000000: consecutive disagreeing cycles required to accept a new level (≥1).
- REPEAT_DELAY, 50000000: cycles from rise to first repeat press (used only with auto-repeat).
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat presses (≥1, auto-repeat only).

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous and active-low.
- raw_in  in  NUM_CH  unsynchronised button/switch levels.
- stable  out  NUM_CH  debounced level per channel.
- rise  out  NUM_CH  one-cycle pulse when stable goes 0→1.
- fall  out  NUM_CH  one-cycle pulse when stable goes 1→0.
- press  out  NUM_CH  rise pulse, plus repeat pulses when auto-repeat is compiled in.
- onehot  out  NUM_CH  highest-index set bit of stable, else all zero.
- any_active  out  1  OR of stable.

## Operation
- Per channel: a 2-flop synchroniser (sync1→sync2) feeds the debounce counter. Counter width is the localparam $clog2(DEBOUNCE_LIMIT+1).
- Each edge with sync2 == stable: counter ← 0.
- Each edge with sync2 != stable and counter < DEBOUNCE_LIMIT-1: counter increments.
- Each edge with sync2 != stable and counter == DEBOUNCE_LIMIT-1: stable ← sync2 and counter ← 0. On the same edge, rise or fall is registered high for exactly one cycle.
- Bounce: any disagreement run shorter than DEBOUNCE_LIMIT is discarded, with no output change.
- Channels are fully independent. Simultaneous flips on several channels give simultaneous pulses.
- onehot and any_active are combinational from stable. Ties resolve to the highest index.
- Reset, including mid-count: sync flops, counters, stable, rise, fall, press and repeat state all go to 0 immediately. The outputs onehot and any_active read 0. An input held high through reset must be fully debounced again after release.

## Timing
- Take edge 1 as the first posedge that samples a new raw_in level held steadily. Then stable and the pulse register update on edge DEBOUNCE_LIMIT+2, and are visible in the following cycle.
- rise, fall and press are high for exactly one clock. They never assert during or in the first cycle after reset.
- onehot and any_active have zero extra latency relative to stable.

## Configuration
- Macro: DEBOUNCE_AUTOREPEAT_EN.
- Defined: each channel has a repeat counter, cleared on rise and whenever stable=0. While stable stays 1, press pulses on the rise cycle, then REPEAT_DELAY cycles after rise, then every REPEAT_PERIOD cycles. A fall cancels the sequence, and no press pulse is generated on the fall cycle.
- Undefined: press is identical to rise. No repeat counters are synthesised. REPEAT_DELAY and REPEAT_PERIOD are ignored.

## Structure
- Package debounce_pkg holds:
  - default constants for DEBOUNCE_LIMIT, REPEAT_DELAY and REPEAT_PERIOD;
  - a priority-encode function returning the highest-set one-hot vector.
- Sub-module debounce_channel covers synchroniser, counter, edge detect and optional repeat. The top generates NUM_CH instances and adds the one-hot/any_active logic.

## Test plan
Simulation parameters: NUM_CH=6, DEBOUNCE_LIMIT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- raw_in[0] 0→1 held from edge k → stable[0]=1 after edge k+5; rise[0] and press[0] high one cycle; onehot=6'b000001; any_active=1.
- raw_in[1] high for 3 cycles, low 2, high 3, then low → stable[1] stays 0; no rise, fall or press.
- raw_in[1] and raw_in[4] held → onehot=6'b010000. Release raw_in[4] → fall[4] one cycle, then onehot=6'b000010.
- With DEBOUNCE_AUTOREPEAT_EN, raw_in[2] held 30 cycles after rise at cycle t → press[2] at t, t+10, t+13, t+16, … until fall. Without the macro → press[2] only at t.
- raw_in[3] held high, rst_n low when counter=2 → all outputs 0 at once. Release with raw_in[3] still high → stable[3]=1 only after 6 further edges.
- Channels 0 and 5 toggle on the same edge → rise[0] and rise[5] in the same cycle; onehot=6'b100000.
